// File: rtl/div_pkg.sv
// div_pkg: shared state type and width constants for divider_seq
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DIV_N = 4;
  function automatic int cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction
  localparam int DIV_CW = cnt_width(DIV_N);
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (shift in a bit, trial subtract)
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   rem,
  input  logic         din,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_next,
  output logic         q
);
  logic [N+1:0] sh;
  always_comb begin
    sh = {rem, din};
    q = sh >= {2'b00, divisor};
    rem_next = q ? (N+1)'(sh - {2'b00, divisor}) : sh[N:0];
  end
endmodule

// File: rtl/divider_seq.sv
// divider_seq: sequential restoring divider, one quotient bit per clock; DIVIDER_DBZ_CHECK_EN enables divide-by-zero short-cut and err flag
module divider_seq
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           err
);
  localparam int CW = (N == DIV_N) ? DIV_CW : cnt_width(N);
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] dvd;
  logic [N-1:0]   dvs;
  logic [N:0]     rem, rem_n;
  logic           qb;
  div_step #(.N(N)) u_step (
    .rem      (rem),
    .din      (dvd[2*N-1]),
    .divisor  (dvs),
    .rem_next (rem_n),
    .q        (qb)
  );
  // dvd shifts dividend bits out of the top while quotient bits enter at the bottom
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
`ifdef DIVIDER_DBZ_CHECK_EN
      err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          dvd <= {dvd[2*N-2:0], qb};
          rem <= rem_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            quotient <= {dvd[2*N-2:0], qb};
            remainder <= rem_n[N-1:0];
`ifdef DIVIDER_DBZ_CHECK_EN
            err <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          if (start) begin
            dvd <= dividend;
            dvs <= divisor;
            rem <= '0;
            cnt <= CW'(2 * N);
`ifdef DIVIDER_DBZ_CHECK_EN
            if (divisor == '0) begin
              state <= DONE;
              done <= 1'b1;
              err <= 1'b1;
              quotient <= '1;
              remainder <= dividend[N-1:0];
            end else begin
              state <= RUN;
              busy <= 1'b1;
            end
`else
            state <= RUN;
            busy <= 1'b1;
`endif
          end
        end
      endcase
    end
  end
`ifndef DIVIDER_DBZ_CHECK_EN
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed tests for divider_seq against a latency/arithmetic reference model
module tb_divider_seq;
  localparam int N = 4;
`ifdef DIVIDER_DBZ_CHECK_EN
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           busy, done, err;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  divider_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask
  // reference model: result is plain arithmetic, done lands 2N edges after acceptance
  int             cyc = 0;
  int             done_at = 0;
  bit             pend = 1'b0;
  bit             m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, p_err = 1'b0;
  logic [2*N-1:0] m_q = '0, p_q = '0;
  logic [N-1:0]   m_r = '0, p_r = '0;
  always @(posedge clk) begin
    bit was_pend;
    cyc++;
    was_pend = pend;
    m_done = 1'b0;
    if (rst) begin
      pend = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_q = '0; m_r = '0;
    end else begin
      if (pend && cyc == done_at) begin
        pend = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_q = p_q; m_r = p_r; m_err = p_err;
      end
      if (start && !was_pend) begin
        p_q = (divisor == 0) ? {2*N{1'b1}} : dividend / divisor;
        p_r = (divisor == 0) ? dividend[N-1:0] : N'(dividend % divisor);
        p_err = DBZ && divisor == 0;
        if (p_err) begin
          m_done = 1'b1; m_q = p_q; m_r = p_r; m_err = 1'b1;
        end else begin
          pend = 1'b1; m_busy = 1'b1; done_at = cyc + 2 * N;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("quotient", 32'(quotient), 32'(m_q));
      chk("remainder", 32'(remainder), 32'(m_r));
      chk("err", 32'(err), 32'(m_err));
      chk("busy_done_excl", 32'(busy & done), 32'(0));
      if (done === 1'b1) done_cnt++;
    end
  end
  task automatic go(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    @(posedge clk); #2;
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk); #2;
    start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
    if (n >= 40) chk("timeout", 32'(n), 32'(0));
  endtask
  task automatic expect_res(input string tag, input int n, input int lat, input int q, input int r, input int e);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_q"}, 32'(quotient), 32'(q));
    chk({tag, "_r"}, 32'(remainder), 32'(r));
    chk({tag, "_err"}, 32'(err), 32'(e));
  endtask
  initial begin
    int n, d0;
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_q", 32'(quotient), 0);
    chk("rst_r", 32'(remainder), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    go(45, 9);   wait_done(n); expect_res("d45_9", n, 9, 5, 0, 0);
    go(255, 15); wait_done(n); expect_res("d255_15", n, 9, 17, 0, 0);
    go(200, 7);  wait_done(n); expect_res("d200_7", n, 9, 28, 4, 0);
    go(13, 0);   wait_done(n); expect_res("d13_0", n, DBZ ? 1 : 9, 255, 13, DBZ ? 1 : 0);
    repeat (2) @(posedge clk);
    d0 = done_cnt;
    go(100, 3);
    repeat (3) @(posedge clk);
    #2; start = 1'b1; dividend = 50; divisor = 5;
    @(posedge clk); #2; start = 1'b0;
    wait_done(n); expect_res("ign", n + 4, 9, 33, 1, 0);
    repeat (12) @(posedge clk);
    chk("ign_single_done", 32'(done_cnt - d0), 1);
    d0 = done_cnt;
    go(100, 3);
    repeat (4) @(posedge clk);
    #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_q", 32'(quotient), 0);
    chk("mid_rst_r", 32'(remainder), 0);
    chk("mid_rst_nodone", 32'(done_cnt - d0), 0);
    go(17, 4);   wait_done(n); expect_res("d17_4", n, 9, 4, 1, 0);
    repeat (2) @(posedge clk);
    go(60, 8);   wait_done(n); expect_res("b2b1", n, 9, 7, 4, 0);
    start = 1'b1; dividend = 9; divisor = 2;
    @(posedge clk); #2; start = 1'b0;
    wait_done(n); expect_res("b2b2", n, 9, 4, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_q", 32'(quotient), 4);
    chk("hold_r", 32'(remainder), 1);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
